// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared encodings for the actuated traffic phase scheduler: states, lamp patterns,
// approach directions and the green-state lookup used by the FSM.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_NS_G = 3'd0,
        S_NS_Y = 3'd1,
        S_EW_G = 3'd2,
        S_EW_Y = 3'd3,
        S_RED  = 3'd4,
        S_PED  = 3'd5
    } state_t;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    function automatic state_t green_of(input logic dir);
        return (dir == DIR_EW) ? S_EW_G : S_NS_G;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request/lamp bundle between the intersection controller and its environment.
// Emergency preemption signals exist only with TRAFFIC_EMERGENCY_PREEMPT_EN.
interface traffic_phase_scheduler_if;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
    logic       emg_req;
    logic       emg_dir;
`endif
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [2:0] phase;

    modport master (
        output ns_req, ew_req, ped_req,
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
        output emg_req, emg_dir,
`endif
        input  ns_light, ew_light, walk, phase
    );

    modport slave (
        input  ns_req, ew_req, ped_req,
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
        input  emg_req, emg_dir,
`endif
        output ns_light, ew_light, walk, phase
    );
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Phase timer: clears on request, otherwise counts up; holds at sat_val while sat_en.
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          sat_en,
    input  logic [TW-1:0] sat_val,
    output logic [TW-1:0] count
);
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (sat_en && count >= sat_val) begin
            count <= sat_val;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated two-road phase scheduler with latched pedestrian walk phase.
// Optional emergency preemption: define TRAFFIC_EMERGENCY_PREEMPT_EN.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 2,
    parameter int WALK_T    = 6,
    parameter int TW        = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    traffic_phase_scheduler_if.slave  bus
);
    localparam logic [TW-1:0] MIN_END  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_END  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_END  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] RED_END  = TW'(ALL_RED_T - 1);
    localparam logic [TW-1:0] WALK_END = TW'(WALK_T - 1);

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic          ped_pend, last_dir, from_ped;
    logic          green, own_dir, own_req, demand, green_exit;
    logic          emg_on, emg_to;
    logic [2:0]    ns_l, ew_l;
    logic          walk_l;

`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
    assign emg_on = bus.emg_req;
    assign emg_to = bus.emg_dir;
`else
    assign emg_on = 1'b0;
    assign emg_to = DIR_NS;
`endif

    assign green = (state == S_NS_G) || (state == S_EW_G);

    phase_timer #(.TW(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_next != state),
        .sat_en  (green),
        .sat_val (MAX_END),
        .count   (timer)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= S_NS_G;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        own_dir    = (state == S_EW_G) ? DIR_EW : DIR_NS;
        own_req    = own_dir ? bus.ew_req : bus.ns_req;
        demand     = (own_dir ? bus.ns_req : bus.ew_req) || ped_pend;
        green_exit = 1'b0;
        // Preemption overrides actuation entirely: wrong-way greens leave at once,
        // the preempted direction holds regardless of max-out.
        if (emg_on) green_exit = (emg_to != own_dir);
        else        green_exit = ((timer >= MIN_END) && demand && !own_req) ||
                                 ((timer == MAX_END) && demand);
        unique case (state)
            S_NS_G, S_EW_G: if (green_exit) state_next = own_dir ? S_EW_Y : S_NS_Y;
            S_NS_Y, S_EW_Y: if (timer == YEL_END) state_next = S_RED;
            S_RED: begin
                if (timer == RED_END) begin
                    if (emg_on)                     state_next = green_of(emg_to);
                    else if (ped_pend && !from_ped) state_next = S_PED;
                    else                            state_next = green_of(~last_dir);
                end
            end
            S_PED:   if (timer == WALK_END) state_next = S_RED;
            default: state_next = S_NS_G;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ped_pend <= 1'b0;
            last_dir <= DIR_NS;
            from_ped <= 1'b0;
        end else begin
            if (state_next == S_PED && state != S_PED) ped_pend <= 1'b0;
            else if (bus.ped_req)                      ped_pend <= 1'b1;
            if (state_next != state) begin
                from_ped <= (state == S_PED);
                if (state == S_NS_Y) last_dir <= DIR_NS;
                if (state == S_EW_Y) last_dir <= DIR_EW;
            end
        end
    end

    always_comb begin
        ns_l   = LT_RED;
        ew_l   = LT_RED;
        walk_l = 1'b0;
        unique case (state)
            S_NS_G:  ns_l = LT_GRN;
            S_NS_Y:  ns_l = LT_YEL;
            S_EW_G:  ew_l = LT_GRN;
            S_EW_Y:  ew_l = LT_YEL;
            S_PED:   walk_l = 1'b1;
            default: ;
        endcase
    end

    assign bus.ns_light = ns_l;
    assign bus.ew_light = ew_l;
    assign bus.walk     = walk_l;
    assign bus.phase    = state;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: literal timeline checks plus a
// per-cycle comparison against a phase-kind/elapsed-time model.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int MIN_GREEN = 8;
    localparam int MAX_GREEN = 20;
    localparam int YELLOW_T  = 3;
    localparam int ALL_RED_T = 2;
    localparam int WALK_T    = 6;

    localparam int K_GRN = 0;
    localparam int K_YEL = 1;
    localparam int K_RED = 2;
    localparam int K_PED = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YELLOW_T  (YELLOW_T),
        .ALL_RED_T (ALL_RED_T),
        .WALK_T    (WALK_T),
        .TW        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: phase kind + direction + elapsed cycles; direction persists through RED/PED
    int   m_kind, m_el, nk;
    logic m_dir, nd, own, opp, go;
    bit   m_pend, m_after_ped, m_valid;

    always @(posedge clk) begin
        if (!reset) begin
            m_kind = K_GRN; m_dir = 1'b0; m_el = 0;
            m_pend = 0; m_after_ped = 0; m_valid = 1;
        end else if (m_valid) begin
            nk = m_kind; nd = m_dir;
            case (m_kind)
                K_GRN: begin
                    own = m_dir ? bus.ew_req : bus.ns_req;
                    opp = (m_dir ? bus.ns_req : bus.ew_req) || m_pend;
                    go  = (m_el >= MIN_GREEN - 1 && opp && !own) || (m_el >= MAX_GREEN - 1 && opp);
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
                    if (bus.emg_req) go = (bus.emg_dir != m_dir);
`endif
                    if (go) nk = K_YEL;
                end
                K_YEL: if (m_el == YELLOW_T - 1) nk = K_RED;
                K_RED: begin
                    if (m_el == ALL_RED_T - 1) begin
                        nk = K_GRN; nd = ~m_dir;
                        if (m_pend && !m_after_ped) begin nk = K_PED; nd = m_dir; end
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
                        if (bus.emg_req) begin nk = K_GRN; nd = bus.emg_dir; end
`endif
                    end
                end
                default: if (m_el == WALK_T - 1) nk = K_RED;
            endcase
            if (nk == K_PED && m_kind != K_PED) m_pend = 0;
            else if (bus.ped_req) m_pend = 1;
            if (nk != m_kind) begin
                m_after_ped = (m_kind == K_PED);
                m_el = 0;
            end else begin
                m_el++;
            end
            m_kind = nk; m_dir = nd;
        end
    end

    function automatic int model_vec();
        logic [2:0] ph, nsl, ewl;
        logic wk;
        ph = S_RED; nsl = 3'b100; ewl = 3'b100; wk = 1'b0;
        case (m_kind)
            K_GRN: if (m_dir) begin ph = S_EW_G; ewl = 3'b001; end
                   else begin ph = S_NS_G; nsl = 3'b001; end
            K_YEL: if (m_dir) begin ph = S_EW_Y; ewl = 3'b010; end
                   else begin ph = S_NS_Y; nsl = 3'b010; end
            K_RED: ph = S_RED;
            default: begin ph = S_PED; wk = 1'b1; end
        endcase
        return int'({ph, nsl, ewl, wk});
    endfunction

    always @(negedge clk) begin
        if (reset && m_valid)
            check("model", int'({bus.phase, bus.ns_light, bus.ew_light, bus.walk}), model_vec());
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic goto_cyc(input int k);
        if (k > cyc) tick(k - cyc);
    endtask

    task automatic clear_inputs();
        bus.ns_req = 0; bus.ew_req = 0; bus.ped_req = 0;
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
        bus.emg_req = 0; bus.emg_dir = 0;
`endif
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_phase"}, bus.phase, S_NS_G);
        check({name, "_ns"}, bus.ns_light, 3'b001);
        check({name, "_ew"}, bus.ew_light, 3'b100);
        check({name, "_walk"}, bus.walk, 0);
    endtask

    // Holds reset across two edges; returns with reset released at cycle 0.
    task automatic do_reset(input string name);
        reset = 0;
        clear_inputs();
        tick(2);
        check_reset_outputs(name);
        reset = 1;
        cyc = 0;
    endtask

    task automatic lit(input string name, input int k, input state_t ph, input int wk);
        goto_cyc(k);
        check({name, "_phase"}, bus.phase, ph);
        check({name, "_walk"}, bus.walk, wk);
    endtask

    task automatic lit_lights(input string name, input int ns, input int ew);
        check({name, "_ns"}, bus.ns_light, ns);
        check({name, "_ew"}, bus.ew_light, ew);
    endtask

    initial begin
        clear_inputs();

        do_reset("rst_idle");
        lit("idle_c0", 0, S_NS_G, 0);   lit_lights("idle_c0", 3'b001, 3'b100);
        lit("idle_c50", 50, S_NS_G, 0);
        lit("idle_c99", 99, S_NS_G, 0); lit_lights("idle_c99", 3'b001, 3'b100);

        do_reset("rst_ew");
        bus.ew_req = 1;
        lit("ew_c7", 7, S_NS_G, 0);
        lit("ew_c8", 8, S_NS_Y, 0);     lit_lights("ew_c8", 3'b010, 3'b100);
        lit("ew_c10", 10, S_NS_Y, 0);
        lit("ew_c11", 11, S_RED, 0);    lit_lights("ew_c11", 3'b100, 3'b100);
        lit("ew_c12", 12, S_RED, 0);
        lit("ew_c13", 13, S_EW_G, 0);   lit_lights("ew_c13", 3'b100, 3'b001);
        lit("ew_c60", 60, S_EW_G, 0);

        do_reset("rst_max");
        bus.ns_req = 1; bus.ew_req = 1;
        lit("max_c19", 19, S_NS_G, 0);
        lit("max_c20", 20, S_NS_Y, 0);
        lit("max_c23", 23, S_RED, 0);
        lit("max_c25", 25, S_EW_G, 0);
        lit("max_c44", 44, S_EW_G, 0);
        lit("max_c45", 45, S_EW_Y, 0);  lit_lights("max_c45", 3'b100, 3'b010);

        do_reset("rst_ped");
        goto_cyc(2);
        bus.ped_req = 1;
        tick(1);
        bus.ped_req = 0;
        lit("ped_c7", 7, S_NS_G, 0);
        lit("ped_c8", 8, S_NS_Y, 0);
        lit("ped_c11", 11, S_RED, 0);
        lit("ped_c12", 12, S_RED, 0);
        lit("ped_c13", 13, S_PED, 1);   lit_lights("ped_c13", 3'b100, 3'b100);
        lit("ped_c18", 18, S_PED, 1);
        lit("ped_c19", 19, S_RED, 0);
        lit("ped_c20", 20, S_RED, 0);
        lit("ped_c21", 21, S_EW_G, 0);
        lit("ped_c50", 50, S_EW_G, 0);

        // Mid-yellow reset with a pending walk: the walk must be forgotten
        do_reset("rst_mid");
        bus.ew_req = 1;
        lit("mid_c13", 13, S_EW_G, 0);
        goto_cyc(14);
        bus.ew_req = 0; bus.ped_req = 1;
        tick(1);
        bus.ped_req = 0;
        lit("mid_c21", 21, S_EW_Y, 0);
        goto_cyc(22);
        reset = 0;
        tick(1);
        check_reset_outputs("mid_rst");
        reset = 1;
        cyc = 0;
        lit("mid_after_c8", 8, S_NS_G, 0);
        lit("mid_after_c40", 40, S_NS_G, 0);

`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
        do_reset("rst_emg");
        bus.ns_req = 1;
        lit("emg_c2", 2, S_NS_G, 0);
        bus.emg_req = 1; bus.emg_dir = 1;
        lit("emg_c3", 3, S_NS_Y, 0);
        lit("emg_c5", 5, S_NS_Y, 0);
        lit("emg_c6", 6, S_RED, 0);
        lit("emg_c7", 7, S_RED, 0);
        lit("emg_c8", 8, S_EW_G, 0);
        lit("emg_c58", 58, S_EW_G, 0);
`endif

        tick(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Actuated phase scheduler for a two-road intersection (north-south / east-west) with a pedestrian walk phase.
- Arbitrates green time between NS vehicle demand, EW vehicle demand and latched pedestrian requests, using min/max-green, yellow and all-red clearance timing.
- Drives the same ns_light/ew_light 3-bit lamp buses used by the intersection light datapath, plus a walk lamp; replaces its fixed-cycle sequencing.

Parameters:
- MIN_GREEN, 8, minimum green cycles per vehicle phase
- MAX_GREEN, 20, maximum green cycles when the own direction still has demand
- YELLOW_T, 3, yellow cycles
- ALL_RED_T, 2, all-red clearance cycles
- WALK_T, 6, pedestrian walk cycles
- TW, 8, phase timer width; all durations must be at least 1 and at most 2^TW

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- ns_req  in  1  NS vehicle sensor, level
- ew_req  in  1  EW vehicle sensor, level
- ped_req  in  1  pedestrian button; any high cycle is latched
- ns_light  out  3  {red, yellow, green} one-hot
- ew_light  out  3  {red, yellow, green} one-hot
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding, for observation

Behaviour:
- States: S_NS_G, S_NS_Y, S_EW_G, S_EW_Y, S_RED (all-red clearance), S_PED (all-red plus walk).
- Moore outputs, decoded from the state register:
  - NS_G: ns=001, ew=100
  - NS_Y: ns=010, ew=100
  - EW_G: ns=100, ew=001
  - EW_Y: ns=100, ew=010
  - RED and PED: both 100
  - walk=1 only in S_PED.
- Timer: cleared to 0 on every state change, otherwise increments each cycle. It saturates at MAX_GREEN-1 in the green states.
- Fixed-duration states exit when timer == DUR-1. Yellow, RED and PED therefore last exactly YELLOW_T, ALL_RED_T and WALK_T cycles.
- ped_pend:
  - Set on any cycle with ped_req=1.
  - Cleared on the transition into S_PED. A ped_req in that same cycle is absorbed by this walk.
  - A ped_req during S_PED sets ped_pend again.
- Green exit, for a green in direction D with opposing direction O:
  - Exit to D-yellow when timer >= MIN_GREEN-1 and (O_req or ped_pend) and not D_req (gap-out).
  - Also exit when timer == MAX_GREEN-1 and (O_req or ped_pend) (max-out).
  - With no opposing request and no ped_pend, rest in green indefinitely.
- Yellow: exits to S_RED. last_dir register records D.
- S_RED exit:
  - If entered from yellow and ped_pend=1, go to S_PED.
  - Otherwise go to the green opposite last_dir.
- S_PED exits to S_RED. The following green is the one opposite last_dir.
- Reset (reset=0 at a clock edge, from any state, mid-phase included):
  - state=S_NS_G, timer=0, ped_pend=0, last_dir=NS.
  - Outputs: ns=001, ew=100, walk=0.

Optional Feature:
- Macro: TRAFFIC_EMERGENCY_PREEMPT_EN.
- When defined, adds two inputs: emg_req (1 bit) and emg_dir (1 bit; 0=NS, 1=EW).
- While emg_req=1:
  - A green in the wrong direction exits to yellow on the next edge, ignoring MIN_GREEN.
  - S_RED always proceeds to green in emg_dir; S_PED is skipped and ped_pend is retained.
  - A green in emg_dir holds; the max-out exit is disabled.
  - Yellow and all-red durations are never shortened.
  - An active S_PED completes its walk first.
- When not defined: the ports are absent and behaviour is exactly as above.

Decomposition:
- Package traffic_pkg holds:
  - the state encodings (3-bit);
  - the light constants LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001;
  - the DIR_NS/DIR_EW encodings.
- One sub-module, phase_timer (TW-bit):
  - inputs clr and sat_en, a saturate value;
  - output count.
- The FSM, ped latch and output decode stay in the top module.

Test Plan:
- No requests after reset release: NS green for 100 cycles, ns=001, ew=100, walk=0 throughout.
- ew_req held, ns_req=0 from cycle 0:
  - NS_G for cycles 0-7, NS_Y 8-10, RED 11-12.
  - EW_G from cycle 13, and it holds.
- ns_req and ew_req both held: NS max-out.
  - NS_G for cycles 0-19, NS_Y 20-22, RED 23-24, EW_G at 25.
  - Same 20-cycle green then in EW.
- Single ped_req pulse at cycle 2, no vehicle demand:
  - NS_Y 8-10, RED 11-12.
  - PED 13-18 with walk=1 and both lights 100.
  - RED 19-20, EW_G at 21, ped_pend=0.
- reset=0 for one edge while in EW_Y with ped_pend=1: next cycle ns=001, ew=100, walk=0. ped_pend is cleared, so there is no walk later absent a new ped_req.
- With TRAFFIC_EMERGENCY_PREEMPT_EN: in NS_G at timer=2, assert emg_req=1, emg_dir=1.
  - NS_Y on the next cycle for 3 cycles, then RED for 2, then EW_G.
  - EW_G holds for 50 cycles despite ns_req=1.
